// File: rtl/fp_pkg.sv
// Shared types and constants for the half-precision multiplier datapath.
package fp_pkg;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fpMulState_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fpClass_t;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] QNAN16   = 16'h7E00;
endpackage

// File: rtl/fp16_unpack.sv
// Splits a half-precision word into sign, exponent, significand (hidden bit) and class.
// Latency: combinational.
// Backpressure: none; pure function of the input word.
module fp16_unpack
  import fp_pkg::*;
#(
  parameter int bitWidth = 16,
  parameter int expWidth = 5,
  parameter int manWidth = 10
) (
  input  logic [bitWidth-1:0] word,
  output logic                sign,
  output logic [expWidth-1:0] expo,
  output logic [manWidth:0]   sig,
  output fpClass_t            cls
);
  logic [manWidth-1:0] frac;

  always_comb begin
    sign = word[bitWidth-1];
    expo = word[bitWidth-2 -: expWidth];
    frac = word[manWidth-1:0];
    sig  = {1'b1, frac};
    // Subnormals are treated as zero, so exponent 0 alone decides ZERO.
    if (expo == '0)
      cls = ZERO;
    else if (expo == {expWidth{1'b1}})
      cls = (frac == '0) ? INF : NAN;
    else
      cls = NORMAL;
  end
endmodule

// File: rtl/fp16_mul_seq.sv
// Sequential fp16 multiplier: shift-add significand product, normalise, truncate.
// Latency: done 13 cycles after accept for normal operands, 1 cycle for specials.
// Backpressure: start ignored while busy; stall holds upstream during MUL/NORM.
module fp16_mul_seq
  import fp_pkg::*;
#(
  parameter int bitWidth = 16,
  parameter int expWidth = 5,
  parameter int manWidth = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                flush,
  input  logic [bitWidth-1:0] a,
  input  logic [bitWidth-1:0] b,
  output logic [bitWidth-1:0] result,
  output logic                done,
  output logic                busy,
  output logic                stall
);
  localparam int SW = manWidth + 1;
  localparam int PW = 2 * SW;
  localparam logic signed [6:0] BIAS7 = EXP_BIAS[6:0];
  localparam logic signed [6:0] EMAX7 = EXP_MAX[6:0];

  fpMulState_t         state;
  logic [3:0]          cnt;
  logic [PW-1:0]       prod;
  logic [SW-1:0]       mcand, mplier;
  logic [expWidth-1:0] ea_q, eb_q;
  logic                sign_q;

  logic                sa, sb;
  logic [expWidth-1:0] ea, eb;
  logic [SW-1:0]       siga, sigb;
  fpClass_t            ca, cb;

  fp16_unpack #(.bitWidth(bitWidth), .expWidth(expWidth), .manWidth(manWidth)) u_unpack_a (
    .word(a), .sign(sa), .expo(ea), .sig(siga), .cls(ca)
  );
  fp16_unpack #(.bitWidth(bitWidth), .expWidth(expWidth), .manWidth(manWidth)) u_unpack_b (
    .word(b), .sign(sb), .expo(eb), .sig(sigb), .cls(cb)
  );

  logic                accept;
  logic                spec_hit;
  logic [bitWidth-1:0] spec_res;
  logic [bitWidth-1:0] norm_res;
  logic signed [6:0]   exp_sum, exp_n;
  logic [manWidth-1:0] frac_n;
  logic                s_in;

  assign accept = start & ~flush & ((state == IDLE) | (state == DONE));
  assign stall  = busy | (start & accept);

  always_comb begin
    s_in     = sa ^ sb;
    spec_hit = (ca != NORMAL) | (cb != NORMAL);
    if ((ca == NAN) | (cb == NAN) | ((ca == INF) & (cb == ZERO)) | ((ca == ZERO) & (cb == INF)))
      spec_res = QNAN16;
    else if ((ca == INF) | (cb == INF))
      spec_res = {s_in, {expWidth{1'b1}}, {manWidth{1'b0}}};
    else
      spec_res = {s_in, {(bitWidth-1){1'b0}}};
  end

  // Significands are in [1,2), so the product's leading one sits at bit 21 or 20.
  always_comb begin
    exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS7;
    if (prod[PW-1]) begin
      exp_n  = exp_sum + 7'sd1;
      frac_n = prod[PW-2 -: manWidth];
    end else begin
      exp_n  = exp_sum;
      frac_n = prod[PW-3 -: manWidth];
    end
    if (exp_n >= EMAX7)
      norm_res = {sign_q, {expWidth{1'b1}}, {manWidth{1'b0}}};
    else if (exp_n <= 7'sd0)
      norm_res = {sign_q, {(bitWidth-1){1'b0}}};
    else
      norm_res = {sign_q, exp_n[expWidth-1:0], frac_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      ea_q   <= '0;
      eb_q   <= '0;
      sign_q <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            sign_q <= s_in;
            ea_q   <= ea;
            eb_q   <= eb;
            mcand  <= siga;
            mplier <= sigb;
            cnt    <= '0;
            prod   <= '0;
            if (spec_hit) begin
              state  <= DONE;
              result <= spec_res;
              done   <= 1'b1;
            end else begin
              state <= MUL;
              busy  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[cnt])
            prod <= prod + (PW'(mcand) << cnt);
          if (cnt == 4'(manWidth))
            state <= NORM;
          else
            cnt <= cnt + 4'd1;
        end
        NORM: begin
          result <= norm_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_mul_seq.sv
// Directed bench for fp16_mul_seq: latency, special cases, range limits, accept and abort paths.
module tb_fp16_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] result;
  logic        done, busy, stall;

  int tests = 0;
  int failed = 0;

  fp16_mul_seq #(.bitWidth(16), .expWidth(5), .manWidth(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .a(a), .b(b), .result(result), .done(done), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive inputs just after a falling edge, then sample 1 time unit later.
  task automatic cyc(input logic s, input logic [15:0] aa, input logic [15:0] bb, input logic f);
    @(negedge clk);
    start = s;
    a     = aa;
    b     = bb;
    flush = f;
    #1;
  endtask

  task automatic run(input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] expv,
                     input logic special, input string tag);
    int d;
    int bad_busy, bad_stall, early;
    logic want;
    d = special ? 1 : 13;
    bad_busy = 0; bad_stall = 0; early = 0;
    cyc(1'b1, aa, bb, 1'b0);
    chk({tag, ".stall0"}, stall, 1);
    for (int k = 1; k <= d; k++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0);
      want = !special && (k <= 12);
      if (busy !== want) bad_busy++;
      if (stall !== want) bad_stall++;
      if (k < d && done !== 1'b0) early++;
    end
    chk({tag, ".busy_profile"}, bad_busy, 0);
    chk({tag, ".stall_profile"}, bad_stall, 0);
    chk({tag, ".early_done"}, early, 0);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".result"}, result, expv);
    cyc(1'b0, 16'h0, 16'h0, 1'b0);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int cnt_done;
    #1;
    chk("reset.result", result, 16'h0000);
    chk("reset.done", done, 0);
    chk("reset.busy", busy, 0);
    chk("reset.stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h3C00, 16'h3C00, 16'h3C00, 1'b0, "one_x_one");
    run(16'h3E00, 16'h3E00, 16'h4080, 1'b0, "norm_hi");
    run(16'hC000, 16'h3C00, 16'hC000, 1'b0, "neg");
    run(16'h7C00, 16'h0000, 16'h7E00, 1'b1, "inf_x_zero");
    run(16'h7C00, 16'hC000, 16'hFC00, 1'b1, "inf_x_neg");
    run(16'h7E01, 16'h3C00, 16'h7E00, 1'b1, "nan");
    run(16'h0001, 16'h3C00, 16'h0000, 1'b1, "subnormal");
    run(16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0, "overflow");
    run(16'h0400, 16'h0400, 16'h0000, 1'b0, "underflow");
    run(16'h3C01, 16'h3C01, 16'h3C02, 1'b0, "truncate");

    // Start during MUL must be dropped without disturbing the operation.
    cnt_done = 0;
    cyc(1'b1, 16'h4000, 16'h3C00, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      cyc(k == 5, 16'h7BFF, 16'h7BFF, 1'b0);
      if (k == 5) chk("ignore.stall_c5", stall, 1);
      if (done) cnt_done++;
    end
    chk("ignore.done_c13", done, 1);
    chk("ignore.done_count", cnt_done, 1);
    chk("ignore.result", result, 16'h4000);
    cyc(1'b0, 16'h0, 16'h0, 1'b0);
    chk("ignore.no_requeue", busy, 0);

    // Back-to-back: new start accepted in the DONE cycle.
    cnt_done = 0;
    cyc(1'b1, 16'h3C00, 16'h3C00, 1'b0);
    for (int k = 1; k <= 12; k++) cyc(1'b0, 16'h0, 16'h0, 1'b0);
    cyc(1'b1, 16'h4000, 16'h4000, 1'b0);
    chk("b2b.first_done", done, 1);
    chk("b2b.first_result", result, 16'h3C00);
    chk("b2b.stall_accept", stall, 1);
    for (int k = 1; k <= 13; k++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0);
      if (k < 13 && done) cnt_done++;
    end
    chk("b2b.early_done", cnt_done, 0);
    chk("b2b.second_done", done, 1);
    chk("b2b.second_result", result, 16'h4400);

    // Flush in cycle 6 aborts the multiply.
    cnt_done = 0;
    cyc(1'b1, 16'h3C00, 16'h3C00, 1'b0);
    for (int k = 1; k <= 5; k++) cyc(1'b0, 16'h0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 16'h0, 1'b0);
    chk("flush.busy", busy, 0);
    chk("flush.result", result, 16'h0000);
    chk("flush.done", done, 0);
    for (int k = 8; k <= 20; k++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0);
      if (done || busy) cnt_done++;
    end
    chk("flush.no_later_activity", cnt_done, 0);

    // Flush and start together: nothing accepted.
    cnt_done = 0;
    cyc(1'b1, 16'h3C00, 16'h3C00, 1'b1);
    chk("flush_start.stall", stall, 0);
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0);
      if (done || busy) cnt_done++;
    end
    chk("flush_start.no_accept", cnt_done, 0);

    // Leave a nonzero result, then reset in cycle 8 of a new multiply.
    run(16'h7C00, 16'hC000, 16'hFC00, 1'b1, "pre_reset");
    cyc(1'b1, 16'h3C00, 16'h3C00, 1'b0);
    for (int k = 1; k <= 7; k++) cyc(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.result", result, 16'h0000);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b0);
      if (done || busy) cnt_done++;
    end
    chk("rst.no_later_done", cnt_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
